read_data_distributor: RTL and testbench

Read-side counterpart of the write arbiter's channel selector. It records which of the 16 ports issued each SRAM read in an in-order tag FIFO. It routes each returned SRAM read word to that port's output holding register. It presents the word to the port with a valid/ready handshake. Per-port credits guarantee that a returning word always finds a free holding register, so the SRAM read path is never back-pressured.

---
 rtl/read_data_distributor.sv | 119 +++++++++++
 tb/tb_read_data_distributor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/read_data_distributor.sv
// read_data_distributor
//   Routes in-order SRAM read returns back to the port that issued each read.
//   An in-order tag FIFO records the issuing port of every accepted read. Each
//   returned word lands in that port's holding register and is offered with a
//   valid/ready handshake. One outstanding read per port (credit) guarantees a
//   free holding register for every return, so the SRAM path never stalls.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   rd_issue        read issued to SRAM this cycle for port rd_issue_port
//   rd_issue_port   issuing port index
//   issue_ready     per-port permission to issue (from registered state only)
//   sram_rd_valid   SRAM return valid, strictly in issue order
//   sram_rd_data    SRAM return word
//   port_data_out   packed holding registers, port p at [(p+1)*W-1 : p*W]
//   port_valid      holding register p holds an unconsumed word
//   port_ready      port p accepts its word
//   last_port       most recently routed port
//   outstanding     tag FIFO occupancy
//   err_overflow    sticky: an issue without issue_ready was dropped
//   err_underflow   sticky: a return with no outstanding tag was dropped
module read_data_distributor #(
    parameter int unsigned num_of_ports       = 16,
    parameter int unsigned arbiter_data_width = 64,
    parameter int unsigned tag_fifo_depth     = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         rd_issue,
    input  logic [$clog2(num_of_ports)-1:0]              rd_issue_port,
    output logic [num_of_ports-1:0]                      issue_ready,
    input  logic                                         sram_rd_valid,
    input  logic [arbiter_data_width-1:0]                sram_rd_data,
    output logic [arbiter_data_width*num_of_ports-1:0]   port_data_out,
    output logic [num_of_ports-1:0]                      port_valid,
    input  logic [num_of_ports-1:0]                      port_ready,
    output logic [$clog2(num_of_ports)-1:0]              last_port,
    output logic [$clog2(tag_fifo_depth):0]              outstanding,
    output logic                                         err_overflow,
    output logic                                         err_underflow
);

    localparam int unsigned PortW = $clog2(num_of_ports);
    localparam int unsigned PtrW  = $clog2(tag_fifo_depth);
    localparam int unsigned CntW  = PtrW + 1;

    logic [PortW-1:0]                                tag_q [tag_fifo_depth];
    logic [PtrW-1:0]                                 wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]                                 count_q;
    logic [num_of_ports-1:0]                         pending_q, valid_q;
    logic [num_of_ports-1:0][arbiter_data_width-1:0] data_q;
    logic [PortW-1:0]                                last_port_q;
    logic                                            err_ovf_q, err_udf_q;

    logic                    full, empty, push, pop;
    logic [PortW-1:0]        head;
    logic [num_of_ports-1:0] handshake, push_mask, pop_mask;

    assign full  = (count_q == CntW'(tag_fifo_depth));
    assign empty = (count_q == '0);

    // One credit per port: a port may not issue again until its word is consumed.
    assign issue_ready = full ? '0 : ~pending_q;

    assign push      = rd_issue & issue_ready[rd_issue_port];
    assign pop       = sram_rd_valid & ~empty;
    assign head      = tag_q[rd_ptr_q];
    assign handshake = valid_q & port_ready;

    always_comb begin
        push_mask = '0;
        pop_mask  = '0;
        if (push) push_mask[rd_issue_port] = 1'b1;
        if (pop)  pop_mask[head]           = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(tag_fifo_depth); i++) tag_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            valid_q     <= '0;
            data_q      <= '0;
            last_port_q <= '0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= rd_issue_port;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + 1'b1;
                data_q[head] <= sram_rd_data;
                last_port_q  <= head;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Held data is left in place after the handshake; only valid drops.
            pending_q <= (pending_q & ~handshake) | push_mask;
            valid_q   <= (valid_q & ~handshake) | pop_mask;
            if (rd_issue && !issue_ready[rd_issue_port]) err_ovf_q <= 1'b1;
            if (sram_rd_valid && empty)                  err_udf_q <= 1'b1;
        end
    end

    assign port_data_out = data_q;
    assign port_valid    = valid_q;
    assign last_port     = last_port_q;
    assign outstanding   = count_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;

endmodule

// File: tb/tb_read_data_distributor.sv
module tb_read_data_distributor;

    localparam int N = 16;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rd_issue = 1'b0;
    logic [3:0]     rd_issue_port = '0;
    logic [N-1:0]   issue_ready;
    logic           sram_rd_valid = 1'b0;
    logic [W-1:0]   sram_rd_data = '0;
    logic [W*N-1:0] port_data_out;
    logic [N-1:0]   port_valid;
    logic [N-1:0]   port_ready = '0;
    logic [3:0]     last_port;
    logic [3:0]     outstanding;
    logic           err_overflow;
    logic           err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the mixed issue/return phase.
    int           q[$];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_valid;
    int           m_last;
    int           rr;

    read_data_distributor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_issue      (rd_issue),
        .rd_issue_port (rd_issue_port),
        .issue_ready   (issue_ready),
        .sram_rd_valid (sram_rd_valid),
        .sram_rd_data  (sram_rd_data),
        .port_data_out (port_data_out),
        .port_valid    (port_valid),
        .port_ready    (port_ready),
        .last_port     (last_port),
        .outstanding   (outstanding),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p);
        rd_issue      = 1'b1;
        rd_issue_port = p[3:0];
        step();
        rd_issue      = 1'b0;
    endtask

    task automatic ret(input logic [63:0] d);
        sram_rd_valid = 1'b1;
        sram_rd_data  = d;
        step();
        sram_rd_valid = 1'b0;
    endtask

    function automatic logic [63:0] pdata(input int p);
        return port_data_out[p*W +: W];
    endfunction

    initial begin
        // Reset with in-flight state
        step();
        check("rst_issue_ready", 64'(issue_ready), 64'hFFFF);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        rst_n = 1'b1;
        step();
        issue(3);
        issue(5);
        check("inflight_outstanding", 64'(outstanding), 64'd2);
        check("inflight_issue_ready", 64'(issue_ready), 64'hFFD7);
        rst_n = 1'b0;
        #1;
        check("midrst_issue_ready", 64'(issue_ready), 64'hFFFF);
        check("midrst_outstanding", 64'(outstanding), 64'd0);
        check("midrst_port_valid", 64'(port_valid), 64'd0);
        check("midrst_last_port", 64'(last_port), 64'd0);
        check("midrst_errs", {62'd0, err_overflow, err_underflow}, 64'd0);
        check("midrst_data", 64'(port_data_out[W*N-1 -: 64] | port_data_out[63:0]), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // In-order routing with a rejected repeat issue
        issue(2);
        issue(7);
        issue(2);
        check("route_err_overflow", 64'(err_overflow), 64'd1);
        check("route_outstanding_2", 64'(outstanding), 64'd2);
        issue(9);
        check("route_outstanding_3", 64'(outstanding), 64'd3);
        ret(64'hAAAA_0000_0000_000A);
        check("route_a_valid", 64'(port_valid), 64'h0004);
        check("route_a_data", pdata(2), 64'hAAAA_0000_0000_000A);
        check("route_a_last", 64'(last_port), 64'd2);
        ret(64'hBBBB_0000_0000_000B);
        check("route_b_valid", 64'(port_valid), 64'h0084);
        check("route_b_data", pdata(7), 64'hBBBB_0000_0000_000B);
        ret(64'hCCCC_0000_0000_000C);
        check("route_c_valid", 64'(port_valid), 64'h0284);
        check("route_c_data", pdata(9), 64'hCCCC_0000_0000_000C);
        check("route_c_last", 64'(last_port), 64'd9);
        check("route_outstanding_0", 64'(outstanding), 64'd0);
        port_ready = 16'h0284;
        step();
        port_ready = '0;
        check("route_consumed_valid", 64'(port_valid), 64'd0);
        check("route_consumed_ready", 64'(issue_ready), 64'hFFFF);
        check("route_data_kept", pdata(2), 64'hAAAA_0000_0000_000A);

        // Backpressure on port 4
        issue(4);
        check("bp_issue_ready_low", 64'(issue_ready[4]), 64'd0);
        ret(64'hD4D4_D4D4_D4D4_D4D4);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_held", 64'(port_valid[4]), 64'd1);
            check("bp_data_held", pdata(4), 64'hD4D4_D4D4_D4D4_D4D4);
            check("bp_no_credit", 64'(issue_ready[4]), 64'd0);
            step();
        end
        port_ready[4] = 1'b1;
        step();
        port_ready = '0;
        check("bp_valid_drop", 64'(port_valid[4]), 64'd0);
        check("bp_credit_back", 64'(issue_ready[4]), 64'd1);

        // FIFO full, then pop with a rejected issue in the same cycle
        for (int p = 0; p < 8; p++) issue(p);
        check("full_outstanding", 64'(outstanding), 64'd8);
        check("full_issue_ready", 64'(issue_ready), 64'd0);
        rd_issue      = 1'b1;
        rd_issue_port = 4'd8;
        ret(64'hE0E0_0000_0000_0000);
        rd_issue      = 1'b0;
        check("full_pop_outstanding", 64'(outstanding), 64'd7);
        check("full_pop_valid", 64'(port_valid), 64'h0001);
        check("full_pop_data", pdata(0), 64'hE0E0_0000_0000_0000);
        check("full_reject_no_pending", 64'(issue_ready[8]), 64'd1);

        // Mixed issue/return across pointer wrap
        q.delete();
        for (int p = 1; p < 8; p++) q.push_back(p);
        m_pend  = 16'h00FF;
        m_valid = 16'h0001;
        m_last  = 0;
        rr      = 8;
        for (int c = 0; c < 20; c++) begin
            int           cand;
            int           popped;
            logic [63:0]  d;
            cand = -1;
            if (q.size() < 8) begin
                for (int k = 0; k < N; k++) begin
                    if (cand < 0 && !m_pend[(rr + k) % N]) cand = (rr + k) % N;
                end
            end
            d             = 64'h1000 + 64'(c);
            port_ready    = m_valid;
            rd_issue      = (cand >= 0);
            rd_issue_port = (cand >= 0) ? cand[3:0] : 4'd0;
            sram_rd_valid = (q.size() > 0);
            sram_rd_data  = d;
            step();
            rd_issue      = 1'b0;
            sram_rd_valid = 1'b0;
            port_ready    = '0;
            m_pend  = m_pend & ~m_valid;
            m_valid = '0;
            popped  = -1;
            if (q.size() > 0) begin
                popped = q.pop_front();
                m_valid[popped] = 1'b1;
                m_last = popped;
            end
            if (cand >= 0) begin
                q.push_back(cand);
                m_pend[cand] = 1'b1;
                rr = (cand + 1) % N;
            end
            if (popped >= 0) begin
                check("wrap_last_port", 64'(last_port), 64'(popped));
                check("wrap_data", pdata(popped), d);
            end
            check("wrap_outstanding", 64'(outstanding), 64'(q.size()));
            check("wrap_valid", 64'(port_valid), 64'(m_valid));
        end
        // Drain remaining tags
        while (q.size() > 0) begin
            int popped;
            port_ready    = m_valid;
            sram_rd_valid = 1'b1;
            sram_rd_data  = 64'h5555;
            step();
            sram_rd_valid = 1'b0;
            m_valid = '0;
            popped  = q.pop_front();
            m_valid[popped] = 1'b1;
            m_last = popped;
        end
        port_ready = '1;
        step();
        port_ready = '0;
        check("drain_outstanding", 64'(outstanding), 64'd0);
        check("drain_valid", 64'(port_valid), 64'd0);
        check("drain_last_port", 64'(last_port), 64'(m_last));

        // Underflow
        check("udf_clear_before", 64'(err_underflow), 64'd0);
        ret(64'hDEAD);
        check("udf_flag", 64'(err_underflow), 64'd1);
        check("udf_valid", 64'(port_valid), 64'd0);
        check("udf_last_port", 64'(last_port), 64'(m_last));
        check("udf_outstanding", 64'(outstanding), 64'd0);

        // Simultaneous push/pop at empty
        rd_issue      = 1'b1;
        rd_issue_port = 4'd1;
        ret(64'hBAD0);
        rd_issue      = 1'b0;
        check("pp_outstanding", 64'(outstanding), 64'd1);
        check("pp_valid", 64'(port_valid), 64'd0);
        check("pp_pending", 64'(issue_ready[1]), 64'd0);
        ret(64'h1111_2222_3333_4444);
        check("pp_route_valid", 64'(port_valid), 64'h0002);
        check("pp_route_data", pdata(1), 64'h1111_2222_3333_4444);
        check("pp_route_last", 64'(last_port), 64'd1);
        check("pp_route_outstanding", 64'(outstanding), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
